complex_div: RTL
================

COMPLEX_DIV -- requirements
Module: complex_div

Interface
REQ-001 SHALL provide the following ports: CLK  input  1  clock, rising-edge active.
REQ-002 SHALL provide: RST_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: start  input  1  one-cycle request; sampled only in IDLE.
REQ-004 SHALL provide: real_a, image_a  input  4 each  signed dividend (a + jb).
REQ-005 SHALL provide: real_b, image_b  input  4 each  signed divisor (c + jd).
REQ-006 SHALL provide: busy  output  1  high from the cycle after start is accepted until done.
REQ-007 SHALL provide: done  output  1  one-cycle pulse; results valid.
REQ-008 SHALL provide: quot_real, quot_image  output  10 each  signed Q6.4 quotient.
REQ-009 SHALL provide: div_zero  output  1  divisor was 0+j0; valid with done.

Function
REQ-010 SHALL compute num_r = a·c + b·d, num_i = b·c − a·d and den = c² + d².
REQ-011 SHALL set quot_real = trunc0(num_r·16/den) and quot_image = trunc0(num_i·16/den). trunc0 truncates toward zero.
REQ-012 SHALL saturate any operand equal to −8 to −7 at capture, so all operands lie in [−7,7].
REQ-013 SHALL implement exactly one shared signed 4x4 multiplier with a registered 7-bit product, time-multiplexed over six products: ac, bd, bc, ad, cc, dd.
REQ-014 SHALL implement an FSM with states IDLE, MUL, SUM, DIV, FIX.
REQ-015 IDLE: on start=1, SHALL capture all four operands and move to MUL with the step counter at 0.
REQ-016 MUL: SHALL issue one product per cycle in the order of REQ-013 and capture each product one cycle after issue, taking 7 cycles total; then SHALL move to SUM.
REQ-017 SUM: SHALL form num_r, num_i (8-bit signed) and den (8-bit unsigned) in one cycle; then SHALL move to DIV.
REQ-018 DIV: SHALL run 11 restoring-division iterations on |num|·16 in parallel for real and imaginary, sharing den, at one iteration per cycle; then SHALL move to FIX.
REQ-019 FIX: SHALL apply the sign of num to each quotient, register the outputs, pulse done and return to IDLE.
REQ-020 Latency SHALL be fixed: done is high in the cycle following the 20th rising edge after the edge that sampled start.
REQ-021 SHALL ignore start while busy=1, with no queuing.
REQ-022 SHALL hold quot_real, quot_image and div_zero stable from done until the next FIX.
REQ-023 If den = 0, SHALL skip DIV, force both quotients to 0 and set div_zero=1 with the same latency as REQ-020.
REQ-024 A zero numerator SHALL yield 0 with no negative-zero artefact.
REQ-025 start asserted in the same cycle that done pulses SHALL be ignored; start SHALL be accepted from the next IDLE cycle.
REQ-026 Quotient magnitude SHALL never exceed 158 (|z1|/|z2| ≤ 7√2), so the result shall not overflow 10 bits.

Reset
REQ-027 While RST_n=0, SHALL force all of the following: FSM=IDLE, step counter=0, busy=0, done=0, div_zero=0, quot_real=0, quot_image=0, and all internal product, sum and divider registers=0.
REQ-028 Reset asserted mid-operation SHALL abort the operation immediately, with no done pulse.
REQ-029 After RST_n is released, SHALL accept start on the first rising edge.

Verification
REQ-030 Bench SHALL drive (3+4j)/(1+2j) -> done at the latency of REQ-020, with quot_real=35 (2.1875), quot_image=−6, div_zero=0.
REQ-031 Bench SHALL drive (−7+0j)/(7+7j) -> quot_real=−8 and quot_image=8.
REQ-032 Bench SHALL drive (5−3j)/(0+0j) -> div_zero=1, both quotients 0, same latency.
REQ-033 Bench SHALL drive (−8−8j)/(1+0j) -> saturation gives quot_real=−112 and quot_image=−112.
REQ-034 Bench SHALL pulse start again at cycle 5 of a busy operation -> it is ignored; there is one done pulse and the results belong to the first operands.
REQ-035 Bench SHALL assert RST_n=0 at cycle 10 of an operation -> all outputs 0 and no done; then start (7+7j)/(1+0j) -> quot_real=112, quot_image=112.

Source files
------------

// File: rtl/complex_div.sv
// complex_div: sequential complex divider (a + jb) / (c + jd), 4-bit signed
// operands, Q6.4 signed quotient. One shared 4x4 multiplier is stepped over
// six products, then a pair of restoring dividers share the denominator.
// Fixed latency: done rises 20 clocks after the edge that accepts start.
//
// Ports
//   CLK, RST_n                 clock (rising edge), async active-low reset
//   start                      one-cycle request, only taken in IDLE
//   real_a, image_a            dividend a + jb (signed 4-bit)
//   real_b, image_b            divisor  c + jd (signed 4-bit)
//   busy                       operation in flight
//   done                       one-cycle pulse, results valid
//   quot_real, quot_image      signed Q6.4 quotient, held until next result
//   div_zero                   divisor was 0 + j0 (quotients forced to 0)
module complex_div (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              start,
  input  logic signed [3:0] real_a,
  input  logic signed [3:0] image_a,
  input  logic signed [3:0] real_b,
  input  logic signed [3:0] image_b,
  output logic              busy,
  output logic              done,
  output logic signed [9:0] quot_real,
  output logic signed [9:0] quot_image,
  output logic              div_zero
);

  typedef enum logic [2:0] {IDLE, MUL, SUM, DIV, FIX} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_step;
  logic signed [3:0] r_a, r_b, r_c, r_d;
  logic signed [3:0] w_ma, w_mb;
  logic signed [6:0] r_prod, r_ac, r_bd, r_bc, r_ad, r_cc, r_dd;
  logic signed [7:0] w_num_r, w_num_i;
  logic [6:0]        w_abs_r, w_abs_i;
  logic [7:0]        w_den, r_den;
  logic              r_neg_r, r_neg_i;
  logic [10:0]       r_qr_r, r_qr_i;   // dividend shifts out, quotient shifts in
  logic [7:0]        r_rem_r, r_rem_i;
  logic [8:0]        w_sh_r, w_sh_i;
  logic              w_ge_r, w_ge_i;
  logic              r_busy, r_done, r_dz;
  logic signed [9:0] r_quot_r, r_quot_i;

  // -8 has no positive counterpart in 4 bits; clamp so |operand| <= 7
  function automatic logic signed [3:0] sat(input logic signed [3:0] v);
    return (v == 4'sb1000) ? 4'sb1001 : v;
  endfunction

  always_ff @(posedge CLK or negedge RST_n)
    if (!RST_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start && !r_done) w_next = MUL;  // start during done pulse is dropped
      MUL:  if (r_step == 4'd6)   w_next = SUM;
      SUM:                        w_next = DIV;
      DIV:  if (r_step == 4'd10)  w_next = FIX;
      FIX:                        w_next = IDLE;
      default:                    w_next = IDLE;
    endcase
  end

  // multiplier operand select: ac, bd, bc, ad, cc, dd
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    case (r_step)
      4'd0: begin w_ma = r_a; w_mb = r_c; end
      4'd1: begin w_ma = r_b; w_mb = r_d; end
      4'd2: begin w_ma = r_b; w_mb = r_c; end
      4'd3: begin w_ma = r_a; w_mb = r_d; end
      4'd4: begin w_ma = r_c; w_mb = r_c; end
      4'd5: begin w_ma = r_d; w_mb = r_d; end
      default: ;
    endcase
  end

  // sums: sign-extend 7-bit products; cc, dd are non-negative
  assign w_num_r = {r_ac[6], r_ac} + {r_bd[6], r_bd};
  assign w_num_i = {r_bc[6], r_bc} - {r_ad[6], r_ad};
  assign w_den   = {1'b0, r_cc} + {1'b0, r_dd};
  assign w_abs_r = 7'(w_num_r[7] ? -w_num_r : w_num_r);
  assign w_abs_i = 7'(w_num_i[7] ? -w_num_i : w_num_i);

  // one restoring step; remainder stays below den so 8 bits suffice
  assign w_sh_r = {r_rem_r, r_qr_r[10]};
  assign w_sh_i = {r_rem_i, r_qr_i[10]};
  assign w_ge_r = (w_sh_r >= {1'b0, r_den});
  assign w_ge_i = (w_sh_i >= {1'b0, r_den});

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_step  <= '0;
      {r_a, r_b, r_c, r_d} <= '0;
      {r_prod, r_ac, r_bd, r_bc, r_ad, r_cc, r_dd} <= '0;
      r_den   <= '0;
      r_neg_r <= 1'b0;
      r_neg_i <= 1'b0;
      r_qr_r  <= '0;
      r_qr_i  <= '0;
      r_rem_r <= '0;
      r_rem_i <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
      r_quot_r <= '0;
      r_quot_i <= '0;
    end else begin
      r_busy <= (w_next != IDLE);
      r_done <= (r_state == FIX);
      r_step <= (w_next != r_state) ? 4'd0 : r_step + 4'd1;
      case (r_state)
        IDLE: if (w_next == MUL) begin
          r_a <= sat(real_a);
          r_b <= sat(image_a);
          r_c <= sat(real_b);
          r_d <= sat(image_b);
        end
        MUL: begin
          r_prod <= 7'({{4{w_ma[3]}}, w_ma} * {{4{w_mb[3]}}, w_mb});
          // product issued in step s-1 lands here in step s
          case (r_step)
            4'd1: r_ac <= r_prod;
            4'd2: r_bd <= r_prod;
            4'd3: r_bc <= r_prod;
            4'd4: r_ad <= r_prod;
            4'd5: r_cc <= r_prod;
            4'd6: r_dd <= r_prod;
            default: ;
          endcase
        end
        SUM: begin
          r_den   <= w_den;
          r_neg_r <= w_num_r[7];
          r_neg_i <= w_num_i[7];
          r_qr_r  <= {w_abs_r, 4'b0000};
          r_qr_i  <= {w_abs_i, 4'b0000};
          r_rem_r <= '0;
          r_rem_i <= '0;
        end
        DIV: if (r_den != 8'd0) begin  // zero divisor: idle through the slots
          r_rem_r <= 8'(w_ge_r ? w_sh_r - {1'b0, r_den} : w_sh_r);
          r_rem_i <= 8'(w_ge_i ? w_sh_i - {1'b0, r_den} : w_sh_i);
          r_qr_r  <= {r_qr_r[9:0], w_ge_r};
          r_qr_i  <= {r_qr_i[9:0], w_ge_i};
        end
        FIX: begin
          r_dz <= (r_den == 8'd0);
          if (r_den == 8'd0) begin
            r_quot_r <= '0;
            r_quot_i <= '0;
          end else begin
            // magnitude <= 158, so the low 10 bits carry the signed result
            r_quot_r <= 10'(r_neg_r ? -r_qr_r : r_qr_r);
            r_quot_i <= 10'(r_neg_i ? -r_qr_i : r_qr_i);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign quot_real  = r_quot_r;
  assign quot_image = r_quot_i;
  assign div_zero   = r_dz;

endmodule
